axis_expander: RTL and testbench

AXI4-Stream sample-rate expander: every accepted input beat is emitted 2^log_expand times on the master port, either held (sample-and-hold) or zero-stuffed. It is the upsampling counterpart of axis_throttler and sits on the generation/playback path, feeding DAC-side cores that run faster than their sample source. Throughput is full-rate: a new input beat is accepted in the same cycle as the last repeat of the previous one.

---
 rtl/axis_expander.sv | 79 +++++++
 tb/tb_axis_expander.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axis_expander.sv
// AXI4-Stream expander: each accepted input beat is emitted 2^log_expand times.
// Define AXIS_EXPANDER_ZERO_STUFF_EN to zero-stuff repeats instead of holding the sample.
module axis_expander #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [4:0]                  log_expand,
  output logic                        S_AXIS_tready,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic [AXIS_TDATA_WIDTH-1:0] data_reg;
  logic [31:0]                 count_reg;
  logic [31:0]                 last_idx_reg;
  logic                        last;
  logic                        accept;
  logic                        xfer;

  assign last   = (count_reg == last_idx_reg);
  assign accept = S_AXIS_tvalid && S_AXIS_tready;
  assign xfer   = M_AXIS_tvalid && M_AXIS_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) state_next = HOLD;
      end
      HOLD: begin
        // A new beat arriving with the last repeat keeps the output busy (no bubble)
        if (xfer && last && !accept) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    S_AXIS_tready = (state_reg == EMPTY) || (M_AXIS_tready && last);
    M_AXIS_tvalid = (state_reg == HOLD);
`ifdef AXIS_EXPANDER_ZERO_STUFF_EN
    M_AXIS_tdata  = (count_reg == 32'd0) ? data_reg : '0;
`else
    M_AXIS_tdata  = data_reg;
`endif
  end

  // Input acceptance only happens in EMPTY or together with the last repeat transfer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_reg     <= '0;
      count_reg    <= 32'd0;
      last_idx_reg <= 32'd0;
    end else if (accept) begin
      data_reg     <= S_AXIS_tdata;
      count_reg    <= 32'd0;
      last_idx_reg <= (32'd1 << log_expand) - 32'd1;
    end else if (xfer && !last) begin
      count_reg    <= count_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_expander.sv
// Directed, table-driven bench for axis_expander; one check line per failing comparison.
module tb_axis_expander;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  log_expand = 5'd0;
  logic        s_tready;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic        m_tready = 1'b0;
  logic        m_tvalid;
  logic [31:0] m_tdata;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AXIS_EXPANDER_ZERO_STUFF_EN
  localparam logic [31:0] REP5 = 32'h0;
`else
  localparam logic [31:0] REP5 = 32'h5;
`endif

  always #5 aclk = ~aclk;

  axis_expander #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .log_expand    (log_expand),
    .S_AXIS_tready (s_tready),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tdata  (s_tdata),
    .M_AXIS_tready (m_tready),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tdata  (m_tdata)
  );

  typedef struct {
    logic        rst_n;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic [4:0]  le;
    logic        e_sr;
    logic        e_mv;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic sv, input logic [31:0] sd,
                     input logic mr, input logic [4:0] le,
                     input logic e_sr, input logic e_mv, input logic [31:0] e_d);
    vec_t v;
    v.rst_n = rst_n; v.sv = sv; v.sd = sd; v.mr = mr; v.le = le;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_d = e_d;
    v.chk_d = e_mv || !rst_n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic sv, input logic [31:0] sd,
                       input logic mr, input logic [4:0] le);
    @(posedge aclk);
    #1;
    aresetn = rst_n; s_tvalid = sv; s_tdata = sd; m_tready = mr; log_expand = le;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held 5 cycles with valid input pending
    for (int i = 0; i < 5; i++) add(0, 1, 32'hDEAD, 1, 2, 1, 0, 32'h0);
    // log_expand=2, A then B back-to-back
    add(1, 1, 32'hA, 1, 2, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) add(1, 1, 32'hB, 1, 2, 0, 1, 32'hA);
    add(1, 1, 32'hB, 1, 2, 1, 1, 32'hA);
    for (int i = 0; i < 3; i++) add(1, 0, 32'h0, 1, 2, 0, 1, 32'hB);
    add(1, 0, 32'h0, 1, 2, 1, 1, 32'hB);
    add(1, 0, 32'h0, 1, 2, 1, 0, 32'h0);
    // log_expand=1 with master ready toggling
    add(1, 1, 32'h11, 1, 1, 1, 0, 32'h0);
    add(1, 1, 32'h22, 0, 1, 0, 1, 32'h11);
    add(1, 1, 32'h22, 1, 1, 0, 1, 32'h11);
    add(1, 1, 32'h22, 0, 1, 0, 1, 32'h11);
    add(1, 1, 32'h22, 1, 1, 1, 1, 32'h11);
    add(1, 0, 32'h0,  0, 1, 0, 1, 32'h22);
    add(1, 0, 32'h0,  1, 1, 0, 1, 32'h22);
    add(1, 0, 32'h0,  0, 1, 0, 1, 32'h22);
    add(1, 0, 32'h0,  1, 1, 1, 1, 32'h22);
    add(1, 0, 32'h0,  1, 1, 1, 0, 32'h0);
    // log_expand 3 -> 1 during the 4th repeat
    add(1, 1, 32'h33, 1, 3, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) add(1, 1, 32'h44, 1, 3, 0, 1, 32'h33);
    for (int i = 0; i < 4; i++) add(1, 1, 32'h44, 1, 1, 0, 1, 32'h33);
    add(1, 1, 32'h44, 1, 1, 1, 1, 32'h33);
    add(1, 0, 32'h0,  1, 1, 0, 1, 32'h44);
    add(1, 0, 32'h0,  1, 1, 1, 1, 32'h44);
    add(1, 0, 32'h0,  1, 1, 1, 0, 32'h0);
    // hold vs zero-stuff
    add(1, 1, 32'h5, 1, 2, 1, 0, 32'h0);
    add(1, 0, 32'h0, 1, 2, 0, 1, 32'h5);
    add(1, 0, 32'h0, 1, 2, 0, 1, REP5);
    add(1, 0, 32'h0, 1, 2, 0, 1, REP5);
    add(1, 0, 32'h0, 1, 2, 1, 1, REP5);
    add(1, 0, 32'h0, 1, 2, 1, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].le);
      @(negedge aclk);
      check("s_tready", i, {31'd0, s_tready}, {31'd0, vecs[i].e_sr});
      check("m_tvalid", i, {31'd0, m_tvalid}, {31'd0, vecs[i].e_mv});
      if (vecs[i].chk_d) check("m_tdata", i, m_tdata, vecs[i].e_d);
    end

    // pass-through: log_expand=0, samples 1..16 streamed continuously
    for (int i = 1; i <= 18; i++) begin
      logic exp_mv;
      exp_mv = (i >= 2) && (i <= 17);
      drive(1'b1, (i <= 16), 32'(i), 1'b1, 5'd0);
      @(negedge aclk);
      check("pt_s_tready", i, {31'd0, s_tready}, 32'd1);
      check("pt_m_tvalid", i, {31'd0, m_tvalid}, {31'd0, exp_mv});
      if (exp_mv) check("pt_m_tdata", i, m_tdata, 32'(i - 1));
    end

    // log_expand=31: long burst must not finish early, then async reset aborts it
    drive(1'b1, 1'b1, 32'h99, 1'b1, 5'd31);
    @(negedge aclk);
    check("l31_s_tready", 0, {31'd0, s_tready}, 32'd1);
    check("l31_m_tvalid", 0, {31'd0, m_tvalid}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 32'h77, 1'b1, 5'd31);
      @(negedge aclk);
      check("l31_s_tready", i, {31'd0, s_tready}, 32'd0);
      check("l31_m_tvalid", i, {31'd0, m_tvalid}, 32'd1);
      check("l31_m_tdata", i, m_tdata, 32'h99);
    end
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("async_rst_m_tvalid", 0, {31'd0, m_tvalid}, 32'd0);
    check("async_rst_m_tdata", 0, m_tdata, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd2);
      @(negedge aclk);
      check("post_rst_m_tvalid", i, {31'd0, m_tvalid}, 32'd0);
      check("post_rst_s_tready", i, {31'd0, s_tready}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
